// File: rtl/hazard_ctrl.sv
// Execute-stage hazard controller: forwarding selects, load-use/PC-write stalls, flushes and a
// start/done FSM for multicycle ops. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Ra1D,
    input  logic [3:0]       Ra2D,
    input  logic [3:0]       Ra1E,
    input  logic [3:0]       Ra2E,
    input  logic [3:0]       WriteAddrE,
    input  logic [3:0]       WriteAddrM,
    input  logic [3:0]       WriteAddrW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             BranchTakenE,
    input  logic             MultiCycleE,
    input  logic             McDone,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             McStart,
    output logic             McTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int RC_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [RC_W-1:0] r_runCnt;
    logic            w_setTimeout;
    logic            w_idleStart;
    logic            w_mcHold;
    logic            w_ldrStall;
    logic            w_pcWrPend;

    // Register 15 is the PC alias and is never a forwarding source.
    function automatic logic [1:0] fwdSel(input logic [3:0] ra, input logic [3:0] wam,
                                          input logic rwm, input logic [3:0] waw,
                                          input logic rww);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'hF) begin
            if (rwm && (ra == wam))
                sel = 2'b10;
            else if (rww && (ra == waw))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        forwardAE = fwdSel(Ra1E, WriteAddrM, RegWriteM, WriteAddrW, RegWriteW);
        forwardBE = fwdSel(Ra2E, WriteAddrM, RegWriteM, WriteAddrW, RegWriteW);
    end

    assign w_ldrStall = MemtoRegE & ((Ra1D == WriteAddrE) | (Ra2D == WriteAddrE))
                        & (WriteAddrE != 4'hF);
    assign w_pcWrPend = PCSrcD | PCSrcE | PCSrcM;

    // Gated by reset so nothing is held or started while the block sits in reset.
    assign w_idleStart = reset & (r_state == IDLE) & MultiCycleE;
    assign w_mcHold    = w_idleStart | (r_state == RUN);

    assign StallF  = w_ldrStall | w_pcWrPend | w_mcHold;
    assign StallD  = w_ldrStall | w_mcHold;
    assign StallE  = w_mcHold;
    assign FlushD  = w_pcWrPend | PCSrcW | BranchTakenE;
    assign FlushE  = (w_ldrStall | BranchTakenE) & ~w_mcHold;
    assign FlushM  = w_mcHold;
    assign McStart = w_idleStart;

    always_comb begin
        w_nextState  = r_state;
        w_setTimeout = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_idleStart)
                    w_nextState = RUN;
            end
            RUN: begin
                if (McDone) begin
                    w_nextState = DONE;
                end else if (r_runCnt == RC_LAST) begin
                    w_nextState  = DONE;
                    w_setTimeout = 1'b1;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_runCnt  <= '0;
            McTimeout <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == RUN)
                r_runCnt <= r_runCnt + RC_W'(1);
            else
                r_runCnt <= '0;
            if (w_setTimeout)
                McTimeout <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (StallF)
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            if (FlushD | FlushE)
                r_flushCnt <= r_flushCnt + CNT_W'(1);
        end
    end

    assign StallCount = r_stallCnt;
    assign FlushCount = r_flushCnt;
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule
